dm_store_buffer: RTL

- Posted-write store buffer between the CPU data-memory port and the data SRAM.
- Every store is captured in a DEPTH-entry FIFO, so stores never wait for the SRAM port.
- The FIFO drains to SRAM in any cycle the CPU is not issuing a load.
- Loads get priority on the SRAM port, and read data is merged byte-accurately with pending buffered stores (store-to-load forwarding).

---
 rtl/cpu_mem_pkg.sv | 13 +
 rtl/sb_fwd_merge.sv | 24 ++
 rtl/dm_store_buffer.sv | 96 +++++++++
 3 files changed

// File: rtl/cpu_mem_pkg.sv
// cpu_mem_pkg: shared types and constants for the data-memory store buffer.
package cpu_mem_pkg;
    localparam int SB_ADDR_W = 14;
    localparam int SB_DATA_W = 32;
    localparam int SRAM_READ_LAT = 1;
    localparam logic [SB_DATA_W-1:0] MASK_NONE = '1;

    typedef struct packed {
        logic [SB_ADDR_W-1:0] addr;
        logic [SB_DATA_W-1:0] data;
        logic [SB_DATA_W-1:0] bweb;
    } sb_entry_t;
endpackage

// File: rtl/sb_fwd_merge.sv
// sb_fwd_merge: folds matching buffered stores into a forwarding mask/data pair,
// oldest entry first so the youngest store owns each bit.
module sb_fwd_merge
    import cpu_mem_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  sb_entry_t              ent_i [DEPTH],
    input  logic [DEPTH-1:0]       vld_i,
    input  logic [SB_ADDR_W-1:0]   addr_i,
    output logic [SB_DATA_W-1:0]   fwd_mask_o,
    output logic [SB_DATA_W-1:0]   fwd_data_o
);
    always_comb begin
        fwd_mask_o = '0;
        fwd_data_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld_i[i] && ent_i[i].addr == addr_i) begin
                fwd_mask_o = fwd_mask_o | ~ent_i[i].bweb;
                fwd_data_o = (fwd_data_o & ent_i[i].bweb) | (ent_i[i].data & ~ent_i[i].bweb);
            end
        end
    end
endmodule

// File: rtl/dm_store_buffer.sv
// dm_store_buffer: posted-write FIFO between the CPU data port and the data SRAM,
// draining on non-load cycles and forwarding pending stores into load data.
module dm_store_buffer
    import cpu_mem_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = SB_ADDR_W,
    parameter int DATA_W = SB_DATA_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDR_W-1:0]        cpu_addr,
    input  logic                     cpu_load,
    input  logic                     cpu_web,
    input  logic [DATA_W-1:0]        cpu_bweb,
    input  logic [DATA_W-1:0]        cpu_wdata,
    output logic [DATA_W-1:0]        cpu_rdata,
    output logic [ADDR_W-1:0]        sram_addr,
    output logic                     sram_web,
    output logic [DATA_W-1:0]        sram_bweb,
    output logic [DATA_W-1:0]        sram_din,
    input  logic [DATA_W-1:0]        sram_dout,
    output logic [$clog2(DEPTH):0]   buf_count,
    output logic                     buf_empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    sb_entry_t                ent_q [DEPTH];
    sb_entry_t                ord   [DEPTH];
    sb_entry_t                head_e;
    logic [DEPTH-1:0]         vld;
    logic [PW-1:0]            head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]            count_q, count_d;
    logic [DATA_W-1:0]        fmask_q, fmask_d, fdata_q, fdata_d, mmask, mdata;
    logic [SRAM_READ_LAT-1:0] ld_q, ld_d;
    logic                     drain, enq, wr;

    assign head_e = ent_q[head_q];
    assign drain  = (count_q != '0) && !cpu_load;
    assign enq    = !cpu_web && !cpu_load;
    assign wr     = rst && drain;

    // Rotate the ring so the merge sees entries oldest-first.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ord[i] = ent_q[head_q + PW'(i)];
            vld[i] = CW'(i) < count_q;
        end
    end

    sb_fwd_merge #(.DEPTH(DEPTH)) u_merge (
        .ent_i      (ord),
        .vld_i      (vld),
        .addr_i     (cpu_addr),
        .fwd_mask_o (mmask),
        .fwd_data_o (mdata)
    );

    assign head_d  = drain ? head_q + PW'(1) : head_q;
    assign tail_d  = enq ? tail_q + PW'(1) : tail_q;
    assign count_d = count_q + CW'(enq) - CW'(drain);
    assign fmask_d = cpu_load ? mmask : '0;
    assign fdata_d = cpu_load ? mdata : fdata_q;
    assign ld_d    = SRAM_READ_LAT'({ld_q, cpu_load});

    always_ff @(posedge clk) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            fmask_q <= '0;
            fdata_q <= '0;
            ld_q    <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            fmask_q <= fmask_d;
            fdata_q <= fdata_d;
            ld_q    <= ld_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst && enq) ent_q[tail_q] <= '{addr: cpu_addr, data: cpu_wdata, bweb: cpu_bweb};
    end

    assign sram_addr = cpu_load ? cpu_addr : head_e.addr;
    assign sram_web  = !wr;
    assign sram_bweb = wr ? head_e.bweb : MASK_NONE;
    assign sram_din  = head_e.data;
    assign cpu_rdata = ld_q[SRAM_READ_LAT-1] ? (sram_dout & ~fmask_q) | (fdata_q & fmask_q) : '0;
    assign buf_count = count_q;
    assign buf_empty = count_q == '0;
endmodule
